alu_seq: RTL
============

ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 SHALL have parameter WIDTH, default 8, operand and result width.
REQ-002 SHALL have parameter OP_W, default 3, opcode width.
REQ-003 SHALL have port clk, input, 1, the single clock; all state SHALL change on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have cmd_valid in 1, cmd_ready out 1, cmd_op in OP_W, cmd_a in WIDTH, cmd_b in WIDTH, cmd_chain in 1: command channel.
REQ-006 SHALL have alu_op out OP_W, alu_a out WIDTH, alu_b out WIDTH: registered drive to the external alu.
REQ-007 SHALL have alu_y in WIDTH, alu_carry in 1, alu_overflow in 1, alu_zero in 1: combinational result from the alu.
REQ-008 SHALL have rsp_valid out 1, rsp_ready in 1, rsp_y out WIDTH, rsp_flags out 3 {carry,overflow,zero}: response channel.
REQ-009 SHALL have txn_cnt out 16, count of completed responses.

Function
REQ-010 SHALL implement FSM with states IDLE, EXEC, RESP.
REQ-011 IDLE: cmd_ready=1; cmd_valid&&cmd_ready SHALL latch cmd_op/a/b into alu_op/alu_a/alu_b and go to EXEC.
REQ-012 EXEC: one cycle for alu settle; on exit, alu_y and flags SHALL be registered into rsp_y/rsp_flags and state SHALL go to RESP.
REQ-013 RESP: rsp_valid=1; rsp_y/rsp_flags SHALL stay stable until rsp_valid&&rsp_ready.
REQ-014 Latency: command accepted at edge N -> rsp_valid high after edge N+2.
REQ-015 On rsp handshake SHALL increment txn_cnt (wraps 16'hFFFF -> 0) and return to IDLE.
REQ-016 cmd_ready SHALL be 0 in EXEC and RESP; no overlap of commands (throughput one per 3 cycles minimum).
REQ-017 SHALL accept a new command only in IDLE; a command offered in the same cycle as a response handshake SHALL be accepted one cycle later.
REQ-018 alu_op/alu_a/alu_b SHALL hold last command values in IDLE and RESP.
REQ-019 rsp_valid SHALL not depend combinationally on rsp_ready; cmd_ready SHALL not depend combinationally on cmd_valid.

Reset
REQ-020 rst_n low SHALL force immediately: state IDLE, cmd_ready 1 after release, rsp_valid 0, rsp_y 0, rsp_flags 0, alu_op 0, alu_a 0, alu_b 0, txn_cnt 0, chain register 0.
REQ-021 Reset during EXEC or RESP SHALL discard the in-flight command with no response and no txn_cnt increment.

Configuration
REQ-022 Macro ALU_SEQ_CHAIN_EN SHALL compile in chaining: cmd_chain=1 at accept SHALL replace cmd_a with the last delivered rsp_y (0 after reset).
REQ-023 Without ALU_SEQ_CHAIN_EN, cmd_chain SHALL be ignored and cmd_a used unmodified; port SHALL remain present.

Structure
REQ-024 Package alu_pkg SHALL hold opcode constants OP_ADD=000, OP_SUB=001, OP_AND=010, OP_OR=011, OP_XOR=100, OP_NOT=101, OP_SHL=110, OP_SHR=111, the state enum and flag bit indices.
REQ-025 alu_seq SHALL instantiate no sub-module; the bench SHALL connect it to the existing alu block.

Verification
REQ-026 Reset then cmd ADD a=127 b=1, rsp_ready=1 -> rsp_y=128, flags carry0 ovfl1 zero0, rsp_valid at N+2, txn_cnt=1.
REQ-027 cmd ADD a=200 b=55 with rsp_ready=0 for 5 cycles -> rsp_y=255, flags 000 held stable all 5 cycles, cmd_ready=0 throughout.
REQ-028 cmd SUB a=0 b=0 -> rsp_y=0, zero=1; back-to-back command held valid during RESP accepted only in next IDLE cycle.
REQ-029 With ALU_SEQ_CHAIN_EN: ADD 15+1 then chained ADD a=x b=1 -> second rsp_y=17; without macro, a=x=3 -> rsp_y=4.
REQ-030 Assert rst_n low during EXEC of ADD 15+1 -> rsp_valid stays 0, txn_cnt stays 0, all outputs zero; next command completes normally.
REQ-031 Preload 65535 completions (or force) then one more -> txn_cnt wraps to 0.

Source files
------------

// File: rtl/alu_pkg.sv
// alu_pkg: opcode constants, sequencer state encoding and response flag
// bit positions shared by alu_seq and anything driving or checking it.
package alu_pkg;

  localparam int unsigned OP_W_DEF = 3;
  localparam int unsigned FLAGS_W  = 3;

  localparam logic [OP_W_DEF-1:0] OP_ADD = 3'b000;
  localparam logic [OP_W_DEF-1:0] OP_SUB = 3'b001;
  localparam logic [OP_W_DEF-1:0] OP_AND = 3'b010;
  localparam logic [OP_W_DEF-1:0] OP_OR  = 3'b011;
  localparam logic [OP_W_DEF-1:0] OP_XOR = 3'b100;
  localparam logic [OP_W_DEF-1:0] OP_NOT = 3'b101;
  localparam logic [OP_W_DEF-1:0] OP_SHL = 3'b110;
  localparam logic [OP_W_DEF-1:0] OP_SHR = 3'b111;

  // rsp_flags = {carry, overflow, zero}
  localparam int unsigned FLAG_CARRY = 2;
  localparam int unsigned FLAG_OVF   = 1;
  localparam int unsigned FLAG_ZERO  = 0;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    EXEC = 2'd1,
    RESP = 2'd2
  } state_e;

  function automatic logic [FLAGS_W-1:0] pack_flags(input logic carry,
                                                     input logic ovf,
                                                     input logic zero);
    logic [FLAGS_W-1:0] f;
    f             = '0;
    f[FLAG_CARRY] = carry;
    f[FLAG_OVF]   = ovf;
    f[FLAG_ZERO]  = zero;
    return f;
  endfunction

endpackage

// File: rtl/alu_seq.sv
// alu_seq: sequences one command at a time through an external
// combinational alu and returns its result over a valid/ready channel.
//   clk, rst_n            : clock, asynchronous active-low reset
//   cmd_valid/cmd_ready   : command handshake (op, a, b, chain)
//   alu_op/alu_a/alu_b    : registered operands to the external alu
//   alu_y/alu_carry/...   : combinational alu result
//   rsp_valid/rsp_ready   : response handshake (rsp_y, rsp_flags)
//   txn_cnt               : number of completed responses, wraps at 16 bits
// Optional feature: define ALU_SEQ_CHAIN_EN so cmd_chain=1 substitutes the
// last delivered rsp_y for cmd_a.
module alu_seq
  import alu_pkg::*;
#(
  parameter int unsigned WIDTH = 8,
  parameter int unsigned OP_W  = 3
) (
  input  logic               clk,
  input  logic               rst_n,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [OP_W-1:0]    cmd_op,
  input  logic [WIDTH-1:0]   cmd_a,
  input  logic [WIDTH-1:0]   cmd_b,
  input  logic               cmd_chain,
  output logic [OP_W-1:0]    alu_op,
  output logic [WIDTH-1:0]   alu_a,
  output logic [WIDTH-1:0]   alu_b,
  input  logic [WIDTH-1:0]   alu_y,
  input  logic               alu_carry,
  input  logic               alu_overflow,
  input  logic               alu_zero,
  output logic               rsp_valid,
  input  logic               rsp_ready,
  output logic [WIDTH-1:0]   rsp_y,
  output logic [FLAGS_W-1:0] rsp_flags,
  output logic [15:0]        txn_cnt
);

  localparam int unsigned CNT_W = 16;

  state_e               state_q, state_d;
  logic                 settle_q, settle_d;
  logic                 cmd_ready_q, cmd_ready_d;
  logic                 rsp_valid_q, rsp_valid_d;
  logic [WIDTH-1:0]     rsp_y_q, rsp_y_d;
  logic [FLAGS_W-1:0]   rsp_flags_q, rsp_flags_d;
  logic [OP_W-1:0]      alu_op_q, alu_op_d;
  logic [WIDTH-1:0]     alu_a_q, alu_a_d;
  logic [WIDTH-1:0]     alu_b_q, alu_b_d;
  logic [CNT_W-1:0]     txn_cnt_q, txn_cnt_d;
  logic [WIDTH-1:0]     a_sel;

`ifdef ALU_SEQ_CHAIN_EN
  // Last delivered result, substituted for cmd_a on a chained command.
  logic [WIDTH-1:0]     chain_q, chain_d;
  assign a_sel = cmd_chain ? chain_q : cmd_a;
`else
  logic                 unused_chain;
  assign unused_chain = cmd_chain;
  assign a_sel        = cmd_a;
`endif

  // State and output registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      settle_q    <= 1'b0;
      cmd_ready_q <= 1'b1;
      rsp_valid_q <= 1'b0;
      rsp_y_q     <= '0;
      rsp_flags_q <= '0;
      alu_op_q    <= '0;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      txn_cnt_q   <= '0;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q     <= '0;
`endif
    end else begin
      state_q     <= state_d;
      settle_q    <= settle_d;
      cmd_ready_q <= cmd_ready_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_y_q     <= rsp_y_d;
      rsp_flags_q <= rsp_flags_d;
      alu_op_q    <= alu_op_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      txn_cnt_q   <= txn_cnt_d;
`ifdef ALU_SEQ_CHAIN_EN
      chain_q     <= chain_d;
`endif
    end
  end

  // Next-state and next-output logic.
  always_comb begin
    state_d     = state_q;
    settle_d    = settle_q;
    rsp_y_d     = rsp_y_q;
    rsp_flags_d = rsp_flags_q;
    alu_op_d    = alu_op_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    txn_cnt_d   = txn_cnt_q;
`ifdef ALU_SEQ_CHAIN_EN
    chain_d     = chain_q;
`endif

    case (state_q)
      IDLE: begin
        if (cmd_valid && cmd_ready_q) begin
          alu_op_d = cmd_op;
          alu_a_d  = a_sel;
          alu_b_d  = cmd_b;
          settle_d = 1'b0;
          state_d  = EXEC;
        end
      end
      EXEC: begin
        // First EXEC cycle is settle margin; the result is captured on the
        // second, so the response appears two edges after the accept.
        if (!settle_q) begin
          settle_d = 1'b1;
        end else begin
          rsp_y_d     = alu_y;
          rsp_flags_d = pack_flags(alu_carry, alu_overflow, alu_zero);
          state_d     = RESP;
        end
      end
      RESP: begin
        if (rsp_ready) begin
          txn_cnt_d = CNT_W'(txn_cnt_q + CNT_W'(1));
`ifdef ALU_SEQ_CHAIN_EN
          chain_d   = rsp_y_q;
`endif
          state_d   = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase

    // Handshake flags follow the next state so they stay registered.
    cmd_ready_d = (state_d == IDLE);
    rsp_valid_d = (state_d == RESP);
  end

  assign cmd_ready = cmd_ready_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_y     = rsp_y_q;
  assign rsp_flags = rsp_flags_q;
  assign alu_op    = alu_op_q;
  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign txn_cnt   = txn_cnt_q;

endmodule
